// File: rtl/uart_tx_fifo_reader.sv
// UART transmitter that pops bytes from a FIFO and serialises them as
// start / data (LSB first) / optional parity / stop, timed by 16x s_tick.
module uart_tx_fifo_reader #(
  parameter int data_bits  = 8,
  parameter int sb_ticks   = 16,
  parameter bit parity_en  = 1'b0,
  parameter bit parity_odd = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       s_tick,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done_tick
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [7:0] DATA_MASK = 8'((1 << data_bits) - 1);
  localparam logic [2:0] N_LAST    = 3'(data_bits - 1);
  localparam logic [4:0] SB_LAST   = 5'(sb_ticks - 1);
  localparam logic [4:0] BIT_LAST  = 5'd15;

  state_t     r_state, w_state_next;
  logic [4:0] r_s, w_s_next;
  logic [2:0] r_n, w_n_next;
  logic [7:0] r_b, w_b_next;
  logic       r_par, w_par_next;
  logic       r_tx, w_tx_next;
  logic       w_pop;
  logic [7:0] w_masked;

  // Pop is gated by reset_n so the FIFO never sees a strobe while held in reset.
  assign w_pop    = (r_state == IDLE) && !fifo_empty && reset_n;
  assign w_masked = fifo_data & DATA_MASK;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_s     <= w_s_next;
      r_n     <= w_n_next;
      r_b     <= w_b_next;
      r_par   <= w_par_next;
      r_tx    <= w_tx_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_s_next     = r_s;
    w_n_next     = r_n;
    w_b_next     = r_b;
    w_par_next   = r_par;
    tx_done_tick = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_pop) begin
          w_b_next     = w_masked;
          w_par_next   = (^w_masked) ^ parity_odd;
          w_s_next     = '0;
          w_state_next = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (r_s == BIT_LAST) begin
            w_s_next     = '0;
            w_n_next     = '0;
            w_state_next = DATA;
          end else begin
            w_s_next = r_s + 5'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (r_s == BIT_LAST) begin
            w_s_next = '0;
            w_b_next = r_b >> 1;
            if (r_n == N_LAST) begin
              w_state_next = parity_en ? PARITY : STOP;
            end else begin
              w_n_next = r_n + 3'd1;
            end
          end else begin
            w_s_next = r_s + 5'd1;
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (r_s == BIT_LAST) begin
            w_s_next     = '0;
            w_state_next = STOP;
          end else begin
            w_s_next = r_s + 5'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (r_s == SB_LAST) begin
            w_s_next     = '0;
            tx_done_tick = 1'b1;
            w_state_next = IDLE;
          end else begin
            w_s_next = r_s + 5'd1;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    // Line level is derived from the state being entered so tx changes on the same edge.
    case (w_state_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_b_next[0];
      PARITY:  w_tx_next = r_par;
      default: w_tx_next = 1'b1;
    endcase
  end

  assign fifo_rd = w_pop;
  assign tx      = r_tx;
  assign tx_busy = (r_state != IDLE) || w_pop;

endmodule
